// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port memory between an instruction-fetch port and a
// data-memory port. Only one access is outstanding at a time. Data requests
// normally win arbitration. A fetch-loss counter makes sure fetch is not
// starved: once fetch has lost STARVE times in a row, fetch wins the next
// arbitration.
//
// Ports
//   clock, reset            : clock and asynchronous active-high reset
//   if_req/if_addr          : fetch read request (level-held until if_valid)
//   if_rdata/if_valid       : fetch read data and its one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata : data request (level-held until dm_valid)
//   dm_rdata/dm_valid       : data read result and its one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata : memory strobe, write enable, address, write data
//   mem_rdata               : memory read data, valid LAT cycles after mem_en
//   stall                   : pipeline freeze while any request is still unanswered
module mem_arbiter #(
  parameter int AW     = 8,
  parameter int LAT    = 2,
  parameter int STARVE = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          stall
);

  localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic          grant;
  logic          grant_dm;
  logic          read_done;
  logic          any_valid;
  logic          sel_dm;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic [SW-1:0] loss_cnt;
  logic [2:0]    wait_cnt;

  // While a valid pulse is out, the completing requester still holds its req.
  // Arbitration simply pauses for that cycle so a stale req is never granted
  // and the loss counter only sees genuinely competing requests.
  assign any_valid = if_valid | dm_valid;
  assign stall     = (if_req & ~if_valid) | (dm_req & ~dm_valid);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, grant decision and memory strobe outputs
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_dm   = 1'b0;
    read_done  = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (!any_valid && (if_req || dm_req)) begin
          grant      = 1'b1;
          // Data wins unless fetch is waiting and has hit the starvation limit.
          grant_dm   = dm_req && !(if_req && (loss_cnt == SW'(STARVE)));
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_en     = 1'b1;
        mem_we     = sel_we;
        mem_addr   = sel_addr;
        mem_wdata  = sel_wdata;
        state_next = sel_we ? IDLE : WAIT;
      end
      WAIT: begin
        if (wait_cnt == 3'(LAT)) begin
          read_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latched request, fetch-loss counter, latency counter and return data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel_dm    <= 1'b0;
      sel_we    <= 1'b0;
      sel_addr  <= '0;
      sel_wdata <= '0;
      loss_cnt  <= '0;
      wait_cnt  <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;

      if (grant) begin
        sel_dm    <= grant_dm;
        sel_we    <= grant_dm & dm_we;
        sel_addr  <= grant_dm ? dm_addr : if_addr;
        sel_wdata <= grant_dm ? dm_wdata : '0;
        if (!grant_dm) begin
          loss_cnt <= '0;
        end else if (if_req && (loss_cnt != SW'(STARVE))) begin
          loss_cnt <= loss_cnt + SW'(1);
        end
      end

      // Writes complete right after the strobe; only the data port writes.
      if (state == ISSUE && sel_we) begin
        dm_valid <= 1'b1;
      end

      if (state == ISSUE && !sel_we) begin
        wait_cnt <= 3'd1;
      end else if (state == WAIT) begin
        wait_cnt <= read_done ? 3'd0 : wait_cnt + 3'd1;
      end

      if (read_done) begin
        if (sel_dm) begin
          dm_rdata <= mem_rdata;
          dm_valid <= 1'b1;
        end else begin
          if_rdata <= mem_rdata;
          if_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. Three instances share clock and reset:
// index 0 uses LAT=2 (main scenarios), index 1 uses LAT=1, index 2 uses LAT=7.
// Each instance has its own memory model that presents read data in exactly
// the cycle LAT after mem_en and drives a garbage word otherwise.
module tb_mem_arbiter;

  localparam logic [31:0] GARB = 32'h0BAD0BAD;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req   [3];
  logic        dm_req   [3];
  logic        dm_we    [3];
  logic        mem_en   [3];
  logic        mem_we   [3];
  logic        if_valid [3];
  logic        dm_valid [3];
  logic        stall    [3];
  logic [7:0]  if_addr  [3];
  logic [7:0]  dm_addr  [3];
  logic [7:0]  mem_addr [3];
  logic [31:0] dm_wdata [3];
  logic [31:0] if_rdata [3];
  logic [31:0] dm_rdata [3];
  logic [31:0] mem_wdata[3];
  logic [31:0] mem_rdata[3];

  logic [31:0] mem    [3][256];
  logic [31:0] rd_hold[3];
  int          pend   [3];

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.AW(8), .LAT(2), .STARVE(4)) dut0 (
    .clock(clock), .reset(reset),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_valid(if_valid[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_rdata(dm_rdata[0]), .dm_valid(dm_valid[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .stall(stall[0])
  );

  mem_arbiter #(.AW(8), .LAT(1), .STARVE(4)) dut1 (
    .clock(clock), .reset(reset),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_valid(if_valid[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_rdata(dm_rdata[1]), .dm_valid(dm_valid[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .stall(stall[1])
  );

  mem_arbiter #(.AW(8), .LAT(7), .STARVE(4)) dut2 (
    .clock(clock), .reset(reset),
    .if_req(if_req[2]), .if_addr(if_addr[2]), .if_rdata(if_rdata[2]), .if_valid(if_valid[2]),
    .dm_req(dm_req[2]), .dm_we(dm_we[2]), .dm_addr(dm_addr[2]), .dm_wdata(dm_wdata[2]),
    .dm_rdata(dm_rdata[2]), .dm_valid(dm_valid[2]),
    .mem_en(mem_en[2]), .mem_we(mem_we[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
    .mem_rdata(mem_rdata[2]), .stall(stall[2])
  );

  function automatic int latOf(input int k);
    case (k)
      1:       return 1;
      2:       return 7;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] memInit(input int k, input int i);
    return 32'hA000_0000 | (32'(k) << 16) | 32'(i);
  endfunction

  // Memory models: a read started by mem_en shows its word only in the cycle
  // LAT after the strobe; writes land on the strobe edge.
  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        pend[k]      <= 0;
        mem_rdata[k] <= GARB;
      end else if (mem_en[k] && mem_we[k]) begin
        mem[k][mem_addr[k]] = mem_wdata[k];
        mem_rdata[k] <= GARB;
      end else if (mem_en[k]) begin
        rd_hold[k] <= mem[k][mem_addr[k]];
        if (latOf(k) == 1) begin
          mem_rdata[k] <= mem[k][mem_addr[k]];
          pend[k]      <= 0;
        end else begin
          mem_rdata[k] <= GARB;
          pend[k]      <= latOf(k) - 1;
        end
      end else if (pend[k] == 1) begin
        mem_rdata[k] <= rd_hold[k];
        pend[k]      <= 0;
      end else begin
        mem_rdata[k] <= GARB;
        if (pend[k] != 0) pend[k] <= pend[k] - 1;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Single read on one port of instance k: checks latency from the grant
  // cycle, exactly one strobe at the right address, stall until valid,
  // returned data, and that the data holds once the pulse is gone.
  task automatic applyStimulus(input int k, input bit dm, input logic [7:0] addr,
                               input int expLat, input logic [31:0] expData, input string tag);
    int          n;
    int          enCnt;
    int          stallBad;
    bit          gotValid;
    logic [7:0]  enAddr;
    logic        enWe;
    logic [31:0] rd;
    if (dm) begin
      dm_req[k]  = 1'b1;
      dm_we[k]   = 1'b0;
      dm_addr[k] = addr;
    end else begin
      if_req[k]  = 1'b1;
      if_addr[k] = addr;
    end
    n = 0; enCnt = 0; stallBad = 0; gotValid = 1'b0; enAddr = '0; enWe = 1'b0;
    while (!gotValid && n < 40) begin
      #1;
      if (stall[k] !== 1'b1) stallBad++;
      tick();
      n++;
      if (mem_en[k] === 1'b1) begin
        enCnt++;
        enAddr = mem_addr[k];
        enWe   = mem_we[k];
      end
      gotValid = dm ? (dm_valid[k] === 1'b1) : (if_valid[k] === 1'b1);
    end
    rd = dm ? dm_rdata[k] : if_rdata[k];
    checkOutput({tag, " latency"}, 32'(n), 32'(expLat));
    checkOutput({tag, " strobe count"}, 32'(enCnt), 32'd1);
    checkOutput({tag, " strobe addr"}, {24'd0, enAddr}, {24'd0, addr});
    checkOutput({tag, " strobe we"}, {31'd0, enWe}, 32'd0);
    checkOutput({tag, " stall held"}, 32'(stallBad), 32'd0);
    checkOutput({tag, " rdata"}, rd, expData);
    if (dm) dm_req[k] = 1'b0; else if_req[k] = 1'b0;
    tick();
    checkOutput({tag, " valid dropped"}, {31'd0, dm ? dm_valid[k] : if_valid[k]}, 32'd0);
    checkOutput({tag, " rdata held"}, dm ? dm_rdata[k] : if_rdata[k], expData);
  endtask

  initial begin
    int enIdx, fetchPos1, fetchPos2, both, ifCnt, pulses;
    int en1At, en2At, dmValidAt, ifValidAt;
    logic [7:0]  en1Addr, en2Addr;
    logic        en1We;
    logic [31:0] en1Data, ifData;

    for (int k = 0; k < 3; k++) begin
      if_req[k] = 1'b0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
      if_addr[k] = '0; dm_addr[k] = '0; dm_wdata[k] = '0;
      for (int i = 0; i < 256; i++) mem[k][i] = memInit(k, i);
    end
    mem[0][5] = 32'h8C22_0004;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset mem_en", {31'd0, mem_en[0]}, 32'd0);
    checkOutput("reset mem_addr", {24'd0, mem_addr[0]}, 32'd0);
    checkOutput("reset if_valid", {31'd0, if_valid[0]}, 32'd0);
    checkOutput("reset dm_valid", {31'd0, dm_valid[0]}, 32'd0);
    checkOutput("reset if_rdata", if_rdata[0], 32'd0);
    checkOutput("reset dm_rdata", dm_rdata[0], 32'd0);
    checkOutput("reset stall", {31'd0, stall[0]}, 32'd0);
    reset = 1'b0;
    tick();

    // Fetch-only read of word 5
    applyStimulus(0, 1'b0, 8'd5, 4, 32'h8C22_0004, "fetch5");

    // Simultaneous fetch read and data write: data first, then fetch
    if_req[0] = 1'b1; if_addr[0] = 8'd3;
    dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 8'd9; dm_wdata[0] = 32'hDEAD_BEEF;
    en1At = 0; en2At = 0; dmValidAt = 0; ifValidAt = 0;
    en1Addr = '0; en2Addr = '0; en1We = 1'b0; en1Data = '0; ifData = '0; both = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (mem_en[0] === 1'b1) begin
        if (en1At == 0) begin
          en1At = n; en1Addr = mem_addr[0]; en1We = mem_we[0]; en1Data = mem_wdata[0];
        end else if (en2At == 0) begin
          en2At = n; en2Addr = mem_addr[0];
        end else begin
          both++;
        end
      end
      if (dm_valid[0] === 1'b1) begin
        dmValidAt = n; dm_req[0] = 1'b0; dm_we[0] = 1'b0;
      end
      if (if_valid[0] === 1'b1) begin
        ifValidAt = n; ifData = if_rdata[0]; if_req[0] = 1'b0;
      end
    end
    checkOutput("simul data strobe cycle", 32'(en1At), 32'd1);
    checkOutput("simul data strobe addr", {24'd0, en1Addr}, 32'd9);
    checkOutput("simul data strobe we", {31'd0, en1We}, 32'd1);
    checkOutput("simul data wdata", en1Data, 32'hDEAD_BEEF);
    checkOutput("simul dm_valid cycle", 32'(dmValidAt), 32'd2);
    checkOutput("simul fetch strobe cycle", 32'(en2At), 32'd4);
    checkOutput("simul fetch strobe addr", {24'd0, en2Addr}, 32'd3);
    checkOutput("simul extra strobes", 32'(both), 32'd0);
    checkOutput("simul if_valid cycle", 32'(ifValidAt), 32'd7);
    checkOutput("simul if_rdata", ifData, memInit(0, 3));

    // Read back the written word through the data port
    applyStimulus(0, 1'b1, 8'd9, 4, 32'hDEAD_BEEF, "dm readback");

    // Starvation: both ports keep requesting; fetch wins every 5th arbitration
    if_req[0] = 1'b1; if_addr[0] = 8'd7;
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 8'd20;
    enIdx = 0; fetchPos1 = 0; fetchPos2 = 0; both = 0; ifCnt = 0;
    for (int n = 0; n < 80 && ifCnt < 2; n++) begin
      tick();
      if (mem_en[0] === 1'b1) begin
        enIdx++;
        if (mem_addr[0] === 8'd7) begin
          if (fetchPos1 == 0) fetchPos1 = enIdx;
          else if (fetchPos2 == 0) fetchPos2 = enIdx;
        end
      end
      if (if_valid[0] === 1'b1 && dm_valid[0] === 1'b1) both++;
      if (if_valid[0] === 1'b1) ifCnt++;
    end
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    checkOutput("starve first fetch position", 32'(fetchPos1), 32'd5);
    checkOutput("starve second fetch position", 32'(fetchPos2), 32'd10);
    checkOutput("starve fetch completions", 32'(ifCnt), 32'd2);
    checkOutput("starve dual valid", 32'(both), 32'd0);
    checkOutput("starve dm_rdata", dm_rdata[0], memInit(0, 20));
    tick();
    tick();

    // Reset during WAIT aborts the read silently
    if_req[0] = 1'b1; if_addr[0] = 8'd5;
    tick();
    checkOutput("abort strobe", {31'd0, mem_en[0]}, 32'd1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("abort mem_en in reset", {31'd0, mem_en[0]}, 32'd0);
    checkOutput("abort if_valid in reset", {31'd0, if_valid[0]}, 32'd0);
    tick();
    checkOutput("abort if_rdata cleared", if_rdata[0], 32'd0);
    if_req[0] = 1'b0;
    reset = 1'b0;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (if_valid[0] === 1'b1 || dm_valid[0] === 1'b1 || mem_en[0] === 1'b1) pulses++;
    end
    checkOutput("abort no activity", 32'(pulses), 32'd0);
    applyStimulus(0, 1'b0, 8'd6, 4, memInit(0, 6), "post-reset fetch");

    // Back-to-back reads at the latency extremes
    applyStimulus(1, 1'b0, 8'd10, 3, memInit(1, 10), "lat1 read a");
    applyStimulus(1, 1'b0, 8'd11, 3, memInit(1, 11), "lat1 read b");
    applyStimulus(2, 1'b0, 8'd12, 9, memInit(2, 12), "lat7 read a");
    applyStimulus(2, 1'b0, 8'd13, 9, memInit(2, 13), "lat7 read b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, the word-address width (256 words, 1 KB).
REQ-002 The block SHALL have parameter LAT, default 2, the memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..7.
REQ-003 The block SHALL have parameter STARVE, default 4, the number of consecutive fetch losses before fetch is forced to win.
REQ-004 Port `clock  in  1`: sole clock; all state changes on its rising edge.
REQ-005 Port `reset  in  1`: asynchronous, active-high reset.
REQ-006 Port `if_req  in  1`: instruction-fetch read request; level-held until if_valid.
REQ-007 Port `if_addr  in  AW`: fetch word address.
REQ-008 Port `if_rdata  out  32`: fetch read data; valid only while if_valid=1.
REQ-009 Port `if_valid  out  1`: one-cycle completion pulse for fetch.
REQ-010 Port `dm_req  in  1`: data-memory request; level-held until dm_valid.
REQ-011 Port `dm_we  in  1`: 1 = write, 0 = read.
REQ-012 Port `dm_addr  in  AW`: data word address.
REQ-013 Port `dm_wdata  in  32`: data to write.
REQ-014 Port `dm_rdata  out  32`: data read result.
REQ-015 Port `dm_valid  out  1`: one-cycle completion pulse for data.
REQ-016 Port `mem_en  out  1`: single-port memory access strobe.
REQ-017 Port `mem_we  out  1`: memory write enable.
REQ-018 Port `mem_addr  out  AW`: memory address.
REQ-019 Port `mem_wdata  out  32`: memory write data.
REQ-020 Port `mem_rdata  in  32`: memory read data.
REQ-021 Port `stall  out  1`: pipeline freeze request.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT; only one memory access SHALL be outstanding at any time.
REQ-023 In IDLE with any request pending, the block SHALL grant exactly one requester, latch its address, we and wdata, and go to ISSUE next cycle.
REQ-024 Priority SHALL go to dm_req over if_req, except when the fetch-loss counter equals STARVE, in which case fetch SHALL be granted.
REQ-025 The fetch-loss counter SHALL increment when if_req and dm_req are both pending and data is granted, clear on any fetch grant, and saturate at STARVE.
REQ-026 In ISSUE, mem_en=1 for exactly one cycle, with mem_we/mem_addr/mem_wdata driven from the latched values; mem_* SHALL be 0 in every other state.
REQ-027 For a write, the block SHALL go from ISSUE to IDLE and pulse dm_valid in the cycle after ISSUE.
REQ-028 For a read, the block SHALL go from ISSUE to WAIT, with a 3-bit counter loaded to 1.
REQ-029 In WAIT, the counter SHALL increment each cycle until it equals LAT; in that cycle mem_rdata SHALL be registered into the granted port's rdata, giving a valid pulse in the next cycle.
REQ-030 Return to IDLE SHALL coincide with the valid pulse.
REQ-031 A new grant MAY be made in the same cycle as the valid pulse, provided the completing requester's req is ignored that cycle.
REQ-032 Total read latency, grant cycle to valid, SHALL be LAT+2 cycles; write latency SHALL be 2 cycles.
REQ-033 if_rdata/dm_rdata SHALL hold their last value between transactions.
REQ-034 stall SHALL be combinational: (if_req & ~if_valid) | (dm_req & ~dm_valid).
REQ-035 Deassertion of req after grant SHALL NOT abort the access; completion still pulses valid.
REQ-036 if_valid and dm_valid SHALL never be asserted together.

Reset
REQ-037 While reset=1, the block SHALL be in IDLE, with fetch-loss counter=0, latency counter=0, all valid=0, all mem_*=0 and all rdata=0.
REQ-038 Reset asserted mid-transaction SHALL abort the transaction with no valid pulse.

Verification
REQ-039 Fetch only: if_req=1, if_addr=5, mem word5=0x8C220004, LAT=2 -> mem_en one cycle with addr 5; if_valid pulses 4 cycles after grant with if_rdata=0x8C220004.
REQ-040 Simultaneous requests: if_req=dm_req=1, dm_we=1, addr 9, wdata 0xDEADBEEF -> data granted first; dm_valid after 2 cycles; fetch is then granted; never two mem_en in one cycle.
REQ-041 Starvation: dm_req held high continuously with if_req=1 -> fetch granted on the 5th arbitration; counter then clears.
REQ-042 Reset mid-WAIT: assert reset during WAIT -> no valid pulse, mem_en=0, IDLE; after release, a fresh request completes normally.
REQ-043 Back-to-back reads with LAT=1 and LAT=7 -> latency LAT+2 each; stall high from req until valid; rdata held between pulses.
